// File: rtl/fwrisc_decode_q.sv
// Queued decode stage: buffers fetched (instr, pc) pairs and decodes the FIFO head.
// It reads the register file and holds one decoded instruction until exec consumes it.
module fwrisc_decode_q #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned REG_ADDR_W = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fetch_valid,
    output logic                    fetch_ready,
    input  logic [31:0]             instr_i,
    input  logic [31:0]             pc_i,
    input  logic                    flush,
    output logic [REG_ADDR_W-1:0]   ra_raddr,
    input  logic [31:0]             ra_rdata,
    output logic [REG_ADDR_W-1:0]   rb_raddr,
    input  logic [31:0]             rb_rdata,
    output logic                    decode_valid,
    input  logic                    exec_complete,
    output logic [31:0]             d_pc,
    output logic [31:0]             d_instr,
    output logic [31:0]             d_rs1_data,
    output logic [31:0]             d_rs2_data,
    output logic [31:0]             d_imm,
    output logic [REG_ADDR_W-1:0]   d_rd_raddr,
    output logic [2:0]              d_i_type,
    output logic                    d_illegal,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_SY = 3'd7
    } fmt_e;

    logic [31:0]           r_instr_q [DEPTH];
    logic [31:0]           r_pc_q    [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  r_valid;
    logic [31:0]           r_pc;
    logic [31:0]           r_instr;
    logic [31:0]           r_rs1;
    logic [31:0]           r_rs2;
    logic [31:0]           r_imm;
    logic [REG_ADDR_W-1:0] r_rd;
    fmt_e                  r_type;
    logic                  r_illegal;

    logic [31:0]           w_head_instr;
    logic [31:0]           w_head_pc;
    logic                  w_push;
    logic                  w_load;
    logic [31:0]           w_imm;
    fmt_e                  w_fmt;
    logic                  w_illegal;

    assign w_head_instr = r_instr_q[r_rd_ptr];
    assign w_head_pc    = r_pc_q[r_rd_ptr];

    assign fetch_ready  = (r_count != CNT_W'(DEPTH)) && !flush;
    assign w_push       = fetch_valid && fetch_ready;
    assign w_load       = (r_count != '0) && (!r_valid || exec_complete) && !flush;

    assign ra_raddr     = REG_ADDR_W'(w_head_instr[19:15]);
    assign rb_raddr     = REG_ADDR_W'(w_head_instr[24:20]);

    always_comb begin
        w_fmt     = FMT_I;
        w_imm     = '0;
        w_illegal = 1'b0;
        case (w_head_instr[6:0])
            7'b0110111, 7'b0010111: begin
                w_fmt = FMT_U;
                w_imm = {w_head_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                w_fmt = FMT_J;
                w_imm = {{12{w_head_instr[31]}}, w_head_instr[19:12], w_head_instr[20],
                         w_head_instr[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: begin
                w_fmt = FMT_I;
                w_imm = {{20{w_head_instr[31]}}, w_head_instr[31:20]};
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                w_imm = {{20{w_head_instr[31]}}, w_head_instr[31:25], w_head_instr[11:7]};
            end
            7'b1100011: begin
                w_fmt = FMT_B;
                w_imm = {{20{w_head_instr[31]}}, w_head_instr[7], w_head_instr[30:25],
                         w_head_instr[11:8], 1'b0};
            end
            7'b0110011: w_fmt = FMT_R;
            7'b1110011: begin
                w_fmt = FMT_SY;
                w_imm = {20'b0, w_head_instr[31:20]};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Storage has no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= instr_i;
            r_pc_q[r_wr_ptr]    <= pc_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_rd      <= '0;
            r_type    <= FMT_R;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_load) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_valid   <= 1'b1;
                r_pc      <= w_head_pc;
                r_instr   <= w_head_instr;
                r_rs1     <= ra_rdata;
                r_rs2     <= rb_rdata;
                r_imm     <= w_imm;
                r_rd      <= REG_ADDR_W'(w_head_instr[11:7]);
                r_type    <= w_fmt;
                r_illegal <= w_illegal;
            end else if (exec_complete) begin
                r_valid <= 1'b0;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign decode_valid = r_valid;
    assign d_pc         = r_pc;
    assign d_instr      = r_instr;
    assign d_rs1_data   = r_rs1;
    assign d_rs2_data   = r_rs2;
    assign d_imm        = r_imm;
    assign d_rd_raddr   = r_rd;
    assign d_i_type     = r_type;
    assign d_illegal    = r_illegal;
    assign q_count      = r_count;

endmodule

// File: tb/tb_fwrisc_decode_q.sv
// Self-checking bench for fwrisc_decode_q: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the stage.
module tb_fwrisc_decode_q;

    localparam int DEPTH = 2;
    localparam int RW    = 6;

    logic                 clock = 1'b0;
    logic                 reset, fetch_valid, fetch_ready, flush;
    logic [31:0]          instr_i, pc_i, ra_rdata, rb_rdata;
    logic [RW-1:0]        ra_raddr, rb_raddr, d_rd_raddr;
    logic                 decode_valid, exec_complete, d_illegal;
    logic [31:0]          d_pc, d_instr, d_rs1_data, d_rs2_data, d_imm;
    logic [2:0]           d_i_type;
    logic [$clog2(DEPTH):0] q_count;

    logic [31:0] regs [32];

    always #5 clock = ~clock;

    assign ra_rdata = regs[ra_raddr[4:0]];
    assign rb_rdata = regs[rb_raddr[4:0]];

    fwrisc_decode_q #(.DEPTH(DEPTH), .REG_ADDR_W(RW)) dut (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .instr_i(instr_i), .pc_i(pc_i), .flush(flush),
        .ra_raddr(ra_raddr), .ra_rdata(ra_rdata), .rb_raddr(rb_raddr), .rb_rdata(rb_rdata),
        .decode_valid(decode_valid), .exec_complete(exec_complete),
        .d_pc(d_pc), .d_instr(d_instr), .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data),
        .d_imm(d_imm), .d_rd_raddr(d_rd_raddr), .d_i_type(d_i_type), .d_illegal(d_illegal),
        .q_count(q_count)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_rs1, m_rs2, m_imm;
    logic [31:0] m_rd;
    logic [2:0]  m_type;
    logic        m_ill;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Immediates built from field arithmetic rather than bit concatenation where practical.
    function automatic void ref_decode(input logic [31:0] i, output logic [31:0] imm,
                                       output logic [2:0] t, output logic ill);
        logic signed [31:0] s;
        logic [31:0]        hi;
        s   = i;
        imm = 32'd0;
        t   = 3'd1;
        ill = 1'b0;
        case (i[6:0])
            7'h37, 7'h17: begin t = 3'd4; imm = i & 32'hFFFF_F000; end
            7'h6F: begin
                t   = 3'd5;
                hi  = s >>> 31;
                imm = (hi << 20) | ({24'd0, i[19:12]} << 12) | ({31'd0, i[20]} << 11)
                      | ({22'd0, i[30:21]} << 1);
            end
            7'h67, 7'h03, 7'h13, 7'h0F: begin hi = s >>> 20; imm = hi; end
            7'h23: begin
                t   = 3'd2;
                hi  = s >>> 25;
                imm = (hi << 5) | {27'd0, i[11:7]};
            end
            7'h63: begin
                t   = 3'd3;
                hi  = s >>> 31;
                imm = (hi << 12) | ({31'd0, i[7]} << 11) | ({26'd0, i[30:25]} << 5)
                      | ({28'd0, i[11:8]} << 1);
            end
            7'h33: t = 3'd0;
            7'h73: begin t = 3'd7; imm = i >> 20; end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic model_update(input logic fv, input logic [31:0] ins, input logic [31:0] p,
                                input logic ec, input logic fl, input logic rst);
        logic rdy, ld;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_valid = 0; m_pc = 0; m_instr = 0; m_rs1 = 0; m_rs2 = 0;
            m_imm = 0; m_rd = 0; m_type = 0; m_ill = 0;
        end else if (fl) begin
            mq.delete();
            m_valid = 0;
        end else begin
            rdy = (mq.size() < DEPTH);
            ld  = (mq.size() > 0) && (!m_valid || ec);
            if (ld) begin
                e       = mq.pop_front();
                m_pc    = e.pc;
                m_instr = e.instr;
                m_rs1   = regs[e.instr[19:15]];
                m_rs2   = regs[e.instr[24:20]];
                m_rd    = 32'(e.instr[11:7]);
                ref_decode(e.instr, m_imm, m_type, m_ill);
                m_valid = 1;
            end else if (ec) begin
                m_valid = 0;
            end
            if (fv && rdy) mq.push_back('{instr: ins, pc: p});
        end
    endtask

    task automatic compare_all();
        check("decode_valid", 32'(decode_valid), 32'(m_valid));
        check("q_count", 32'(q_count), 32'(mq.size()));
        check("fetch_ready", 32'(fetch_ready), 32'((mq.size() < DEPTH) && !flush));
        if (mq.size() > 0) begin
            check("ra_raddr", 32'(ra_raddr), 32'(mq[0].instr[19:15]));
            check("rb_raddr", 32'(rb_raddr), 32'(mq[0].instr[24:20]));
        end
        check("d_pc", d_pc, m_pc);
        check("d_instr", d_instr, m_instr);
        check("d_rs1_data", d_rs1_data, m_rs1);
        check("d_rs2_data", d_rs2_data, m_rs2);
        check("d_imm", d_imm, m_imm);
        check("d_rd_raddr", 32'(d_rd_raddr), m_rd);
        check("d_i_type", 32'(d_i_type), 32'(m_type));
        check("d_illegal", 32'(d_illegal), 32'(m_ill));
    endtask

    task automatic cyc(input logic fv, input logic [31:0] ins, input logic [31:0] p,
                       input logic ec, input logic fl, input logic rst);
        fetch_valid   = fv;
        instr_i       = ins;
        pc_i          = p;
        exec_complete = ec;
        flush         = fl;
        reset         = rst;
        @(posedge clock);
        model_update(fv, ins, p, ec, fl, rst);
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] rand_instr(input logic allow_illegal);
        logic [6:0] ops [11];
        logic [31:0] r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h73, 7'h0F};
        r = $urandom;
        if (allow_illegal && $urandom_range(0, 9) == 0) return (r & ~32'h7F) | 32'h7F;
        return (r & ~32'h7F) | {25'd0, ops[$urandom_range(0, 10)]};
    endfunction

    initial begin
        logic [31:0] pc;
        for (int k = 0; k < 32; k++) regs[k] = (k == 0) ? 32'd0 : $urandom;
        fetch_valid = 0; instr_i = 0; pc_i = 0; exec_complete = 0; flush = 0; reset = 1;
        m_valid = 0;

        // Reset state
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("rst_decode_valid", 32'(decode_valid), 0);
        check("rst_q_count", 32'(q_count), 0);
        check("rst_d_imm", d_imm, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("post_rst_fetch_ready", 32'(fetch_ready), 1);

        // addi x1,x2,-1: two-cycle latency
        cyc(1, 32'hFFF1_0093, 32'h100, 0, 0, 0);
        check("addi_ra_raddr", 32'(ra_raddr), 2);
        check("addi_not_yet_valid", 32'(decode_valid), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("addi_valid", 32'(decode_valid), 1);
        check("addi_imm", d_imm, 32'hFFFF_FFFF);
        check("addi_rd", 32'(d_rd_raddr), 1);
        check("addi_type", 32'(d_i_type), 1);
        check("addi_pc", d_pc, 32'h100);
        cyc(0, 0, 0, 0, 0, 0);
        check("addi_held", 32'(decode_valid), 1);
        cyc(0, 0, 0, 1, 0, 0);

        // beq then lui
        cyc(1, 32'hFE00_0EE3, 32'h200, 0, 0, 0);
        cyc(1, 32'h1234_52B7, 32'h204, 0, 0, 0);
        check("beq_imm", d_imm, 32'hFFFF_FFFC);
        check("beq_type", 32'(d_i_type), 3);
        cyc(0, 0, 0, 1, 0, 0);
        check("lui_imm", d_imm, 32'h1234_5000);
        check("lui_type", 32'(d_i_type), 4);
        check("lui_rd", 32'(d_rd_raddr), 5);
        cyc(0, 0, 0, 1, 0, 0);
        check("drained", 32'(decode_valid), 0);

        // Fill with exec stalled, then offer one more which must be held off
        pc = 32'h1000;
        for (int k = 0; k < DEPTH + 1; k++) begin
            cyc(1, rand_instr(0), pc, 0, 0, 0);
            pc += 4;
        end
        check("full_q_count", 32'(q_count), DEPTH);
        check("full_fetch_ready", 32'(fetch_ready), 0);
        cyc(1, rand_instr(0), 32'hDEAD_0000, 0, 0, 0);
        for (int k = 0; k < DEPTH + 2; k++) cyc(0, 0, 0, 1, 0, 0);

        // Steady push+pop across pointer wrap
        cyc(1, rand_instr(0), pc, 1, 0, 0);
        pc += 4;
        for (int k = 0; k < 8; k++) begin
            cyc(1, rand_instr(0), pc, 1, 0, 0);
            pc += 4;
            check("steady_q_count", 32'(q_count), 1);
            check("steady_valid", 32'(decode_valid), 1);
        end
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);

        // Flush with FIFO full and stage valid, while a fetch is offered
        for (int k = 0; k < DEPTH + 1; k++) begin
            cyc(1, rand_instr(0), pc, 0, 0, 0);
            pc += 4;
        end
        cyc(1, 32'h0000_0013, 32'hBAD0_0000, 1, 1, 0);
        check("flush_q_count", 32'(q_count), 0);
        check("flush_valid", 32'(decode_valid), 0);
        check("flush_fetch_ready", 32'(fetch_ready), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 0, 0);
            check("flushed_never_seen", 32'(d_pc != 32'hBAD0_0000), 1);
        end

        // Illegal opcode
        cyc(1, 32'hABCD_EF7F, 32'h300, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("illegal_flag", 32'(d_illegal), 1);
        check("illegal_imm", d_imm, 0);
        check("illegal_type", 32'(d_i_type), 1);

        // Reset mid-stream
        cyc(1, rand_instr(0), 32'h400, 0, 0, 0);
        cyc(1, rand_instr(0), 32'h404, 0, 0, 0);
        cyc(1, 32'h0000_0013, 32'h408, 0, 0, 1);
        check("midrst_valid", 32'(decode_valid), 0);
        check("midrst_q_count", 32'(q_count), 0);
        check("midrst_d_pc", d_pc, 0);
        check("midrst_d_illegal", 32'(d_illegal), 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            regs[$urandom_range(1, 31)] = $urandom;
            cyc($urandom_range(0, 3) != 0, rand_instr(1), pc,
                $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
                $urandom_range(0, 99) == 0);
            pc += 4;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
